// File: rtl/entrada_tempo_pkg.sv
// Shared types and constants for the microwave time-entry block.
// Holds FSM state encodings, BCD limits and the mm:ss field layout.
package entrada_tempo_pkg;

    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned DIG_W    = 4;
    localparam int unsigned TIME_W   = N_DIGITS * DIG_W;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MIN_W    = 8;

    localparam logic [DIG_W-1:0]  DIG_MAX   = 4'd9;
    localparam logic [DIG_W-1:0]  SEC_T_MAX = 4'd5;
    localparam logic [DIG_W-1:0]  SEC_WRAP  = 4'd6;
    localparam logic [MIN_W-1:0]  MIN_SAT   = 8'd99;
    localparam logic [TIME_W-1:0] TIME_SAT  = 16'h9959;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_RUN,
        ST_FINISH
    } state_e;

    // Field view of a 16-bit BCD time word {min_t, min_u, sec_t, sec_u}
    typedef struct packed {
        logic [DIG_W-1:0] min_t;
        logic [DIG_W-1:0] min_u;
        logic [DIG_W-1:0] sec_t;
        logic [DIG_W-1:0] sec_u;
    } mmss_t;

endpackage

// File: rtl/entrada_tempo_if.sv
// Keypad/control inputs and counter-chain outputs of the time-entry block.
interface entrada_tempo_if;

    logic                                      key_valid;
    logic [entrada_tempo_pkg::DIG_W-1:0]       key_code;
    logic                                      start;
    logic                                      cancel;
    logic                                      count_zero;
    logic [entrada_tempo_pkg::TIME_W-1:0]      entry;
    logic [entrada_tempo_pkg::CNT_W-1:0]       n_digits;
    logic [entrada_tempo_pkg::TIME_W-1:0]      data;
    logic                                      load;
    logic                                      en;
    logic                                      running;
    logic                                      done;

    modport master (
        output key_valid, key_code, start, cancel, count_zero,
        input  entry, n_digits, data, load, en, running, done
    );

    modport slave (
        input  key_valid, key_code, start, cancel, count_zero,
        output entry, n_digits, data, load, en, running, done
    );

endinterface

// File: rtl/entrada_tempo_normaliza.sv
// Combinational mm:ss normaliser: folds seconds 60-99 into the next minute
// and saturates at 99:59 when the minute carry overflows.
module normaliza_tempo
    import entrada_tempo_pkg::*;
(
    input  logic [TIME_W-1:0] entry_i,
    output logic [TIME_W-1:0] data_o
);

    mmss_t            e_c;
    mmss_t            d_c;
    logic [MIN_W-1:0] mins_inc_c;

    assign e_c        = mmss_t'(entry_i);
    assign mins_inc_c = MIN_W'(e_c.min_t) * MIN_W'(10) + MIN_W'(e_c.min_u) + MIN_W'(1);

    always_comb begin
        d_c = e_c;
        if (e_c.sec_t > SEC_T_MAX) begin
            if (mins_inc_c > MIN_SAT) begin
                d_c = mmss_t'(TIME_SAT);
            end else begin
                d_c.sec_t = e_c.sec_t - SEC_WRAP;
                // BCD increment of the minutes pair
                if (e_c.min_u == DIG_MAX) begin
                    d_c.min_u = '0;
                    d_c.min_t = e_c.min_t + DIG_W'(1);
                end else begin
                    d_c.min_u = e_c.min_u + DIG_W'(1);
                end
            end
        end
    end

    assign data_o = TIME_W'(d_c);

endmodule

// File: rtl/entrada_tempo.sv
// Keypad-side writer for the microwave BCD countdown chain: collects digits,
// loads the normalised mm:ss value, enables counting and reports completion.
module entrada_tempo
    import entrada_tempo_pkg::*;
(
    input  logic            clk,
    input  logic            clear,
    entrada_tempo_if.slave  bus
);

    state_e              state_q;
    logic [TIME_W-1:0]   entry_q;
    logic [TIME_W-1:0]   data_q;
    logic [CNT_W-1:0]    ndig_q;
    logic                load_q;
    logic                en_q;
    logic                running_q;
    logic                done_q;
    logic                first_q;

    logic [TIME_W-1:0]   norm_c;
    logic                digit_c;

    assign digit_c = bus.key_valid && (bus.key_code <= DIG_MAX);

    normaliza_tempo u_normaliza (
        .entry_i (entry_q),
        .data_o  (norm_c)
    );

    // Counters load at the end of LOAD, so count_zero is stale until after the
    // first RUN cycle; first_q masks it for that cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            entry_q   <= '0;
            data_q    <= '0;
            ndig_q    <= '0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (digit_c) begin
                        entry_q <= TIME_W'(bus.key_code);
                        ndig_q  <= CNT_W'(1);
                        state_q <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (bus.cancel) begin
                        entry_q <= '0;
                        ndig_q  <= '0;
                        state_q <= ST_IDLE;
                    end else if (bus.start && (entry_q != '0)) begin
                        data_q  <= norm_c;
                        load_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else if (digit_c && (ndig_q < CNT_W'(N_DIGITS))) begin
                        entry_q <= {entry_q[TIME_W-DIG_W-1:0], bus.key_code};
                        ndig_q  <= ndig_q + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    en_q      <= 1'b1;
                    running_q <= 1'b1;
                    first_q   <= 1'b1;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    first_q <= 1'b0;
                    if (bus.cancel) begin
                        en_q      <= 1'b0;
                        running_q <= 1'b0;
                        entry_q   <= '0;
                        ndig_q    <= '0;
                        state_q   <= ST_IDLE;
                    end else if (!first_q && bus.count_zero) begin
                        en_q      <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        entry_q   <= '0;
                        ndig_q    <= '0;
                        state_q   <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.entry    = entry_q;
    assign bus.n_digits = ndig_q;
    assign bus.data     = data_q;
    assign bus.load     = load_q;
    assign bus.en       = en_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_entrada_tempo.sv
// Bench for entrada_tempo: directed key sequences, with load/done strobes
// checked against an expected-event queue by a separate monitor.
module tb_entrada_tempo;

    typedef struct {
        logic        is_done;
        logic [15:0] data;
        logic [15:0] entry;
    } ev_t;

    logic clk;
    logic clear;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    entrada_tempo_if bus ();

    entrada_tempo dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic key(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic press_cancel();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
    endtask

    task automatic expect_load(input logic [15:0] d, input logic [15:0] e);
        ev_t ev;
        ev.is_done = 1'b0;
        ev.data    = d;
        ev.entry   = e;
        exp_q.push_back(ev);
    endtask

    task automatic expect_done(input logic [15:0] d);
        ev_t ev;
        ev.is_done = 1'b1;
        ev.data    = d;
        ev.entry   = 16'h0000;
        exp_q.push_back(ev);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_entry"}, bus.entry, 16'h0000);
        chk({name, "_ndig"}, 16'(bus.n_digits), 16'h0000);
        chk({name, "_data"}, bus.data, 16'h0000);
        chk({name, "_ctl"}, 16'({bus.load, bus.en, bus.running, bus.done}), 16'h0000);
    endtask

    // Monitor: every load or done strobe must match the oldest expected event
    always @(negedge clk) begin
        if (bus.load || bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: load=%b done=%b data=%h entry=%h at %0t",
                         bus.load, bus.done, bus.data, bus.entry, $time);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                if ((bus.done !== ev.is_done) || (bus.load !== !ev.is_done) ||
                    (bus.data !== ev.data) || (bus.entry !== ev.entry) ||
                    (bus.en !== 1'b0)) begin
                    errors++;
                    $display("FAIL strobe_event: got done=%b load=%b data=%h entry=%h en=%b expected done=%b data=%h entry=%h en=0 at %0t",
                             bus.done, bus.load, bus.data, bus.entry, bus.en,
                             ev.is_done, ev.data, ev.entry, $time);
                end
            end
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        clear          = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        bus.count_zero = 1'b0;
        tick();
        tick();
        clear = 1'b0;
        chk_all_zero("reset");

        // 1,3,0 -> 01:30, then count down to zero 10 cycles after load
        key(4'd1);
        key(4'd3);
        key(4'd0);
        chk("t1_entry", bus.entry, 16'h0130);
        chk("t1_ndig", 16'(bus.n_digits), 16'd3);
        expect_load(16'h0130, 16'h0130);
        press_start();
        chk("t1_load_en", 16'({bus.load, bus.en}), 16'b10);
        tick();
        chk("t1_run", 16'({bus.load, bus.en, bus.running}), 16'b011);
        repeat (9) tick();
        chk("t1_en_hold", 16'(bus.en), 16'd1);
        bus.count_zero = 1'b1;
        expect_done(16'h0130);
        tick();
        bus.count_zero = 1'b0;
        chk("t1_finish", 16'({bus.done, bus.en, bus.running}), 16'b100);
        chk("t1_fin_ndig", 16'(bus.n_digits), 16'd0);
        tick();
        chk("t1_idle", 16'({bus.done, bus.en, bus.entry}), 16'h0000);

        // 9,0 -> 90 s normalised to 01:30; count_zero masked in LOAD/first RUN, then cancel
        key(4'd9);
        key(4'd0);
        chk("t2_entry", bus.entry, 16'h0090);
        expect_load(16'h0130, 16'h0090);
        press_start();
        bus.count_zero = 1'b1;
        tick();
        chk("t2_run", 16'(bus.en), 16'd1);
        tick();
        chk("t2_mask", 16'({bus.en, bus.running, bus.done}), 16'b110);
        bus.count_zero = 1'b0;
        tick();
        press_cancel();
        chk("t2_cancel", 16'({bus.en, bus.running, bus.done}), 16'b000);
        chk("t2_cancel_entry", bus.entry, 16'h0000);
        chk("t2_data_kept", bus.data, 16'h0130);
        repeat (3) tick();

        // 9,9,9,9,5 -> fifth key ignored, saturates to 99:59
        key(4'd9);
        key(4'd9);
        key(4'd9);
        key(4'd9);
        key(4'd5);
        chk("t3_entry", bus.entry, 16'h9999);
        chk("t3_ndig", 16'(bus.n_digits), 16'd4);
        expect_load(16'h9959, 16'h9999);
        press_start();
        tick();
        press_cancel();
        chk("t3_cancel", 16'(bus.running), 16'd0);

        // 1,5,9 -> already valid 01:59
        key(4'd1);
        key(4'd5);
        key(4'd9);
        expect_load(16'h0159, 16'h0159);
        press_start();
        tick();
        press_cancel();

        // start with no digits, zero entry and invalid codes are all ignored
        press_start();
        chk("t4_idle_start", 16'({bus.load, 3'(bus.n_digits)}), 16'h0000);
        key(4'd0);
        key(4'd0);
        chk("t4_zero_ndig", 16'(bus.n_digits), 16'd2);
        press_start();
        chk("t4_zero_noload", 16'({bus.load, bus.en}), 16'h0000);
        key(4'hA);
        chk("t4_code_a", 16'(bus.n_digits), 16'd2);
        key(4'hF);
        key(4'd5);
        chk("t4_after_bad", bus.entry, 16'h0005);
        chk("t4_ndig3", 16'(bus.n_digits), 16'd3);

        // clear mid-ENTRY zeroes everything
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all_zero("clear");

        repeat (3) tick();
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
